// File: rtl/calc_key_fsm_multi.sv
// Calculator keypad interpreter with multi-digit BCD operands.
// Builds operands A and B, latches +/-, hands off to the ALU and holds the result.
module calc_key_fsm_multi #(
    parameter int unsigned DIGITS = 4,
    parameter bit          CHAIN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic                  key_tipo,
    input  logic [3:0]            key_code,
    input  logic                  alu_done,
    input  logic [4*DIGITS-1:0]   alu_result,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic                  op_sub,
    output logic                  calc_start,
    output logic [4*DIGITS-1:0]   result_q,
    output logic [2:0]            OE,
    output logic                  err,
    output logic [2:0]            state
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER_A = 3'd1,
        OP_WAIT = 3'd2,
        ENTER_B = 3'd3,
        CALC    = 3'd4,
        SHOW    = 3'd5
    } state_t;

    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  op_a_d, op_b_d, result_d;
    logic          op_sub_d, start_d, err_d;
    logic [2:0]    oe_d;

    logic key_num, key_op, key_eq, key_clr, key_bad, room;

    // Key classification; anything valid but unrecognised is rejected.
    assign key_num = key_valid && !key_tipo && (key_code <= 4'd9);
    assign key_op  = key_valid &&  key_tipo && (key_code == 4'hA || key_code == 4'hB);
    assign key_eq  = key_valid &&  key_tipo && (key_code == 4'hC);
    assign key_clr = key_valid &&  key_tipo && (key_code == 4'hF);
    assign key_bad = key_valid && !(key_num || key_op || key_eq || key_clr);
    assign room    = (cnt_q < CW'(DIGITS));
    assign state   = st_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q       <= IDLE;
            cnt_q      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            calc_start <= 1'b0;
            result_q   <= '0;
            OE         <= 3'd0;
            err        <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            op_a       <= op_a_d;
            op_b       <= op_b_d;
            op_sub     <= op_sub_d;
            calc_start <= start_d;
            result_q   <= result_d;
            OE         <= oe_d;
            err        <= err_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a;
        op_b_d   = op_b;
        op_sub_d = op_sub;
        result_d = result_q;
        start_d  = 1'b0;
        err_d    = 1'b0;
        oe_d     = 3'd0;

        if (key_clr) begin
            st_d     = IDLE;
            cnt_d    = '0;
            op_a_d   = '0;
            op_b_d   = '0;
            op_sub_d = 1'b0;
            result_d = '0;
        end else begin
            err_d = key_bad;
            unique case (st_q)
                IDLE: begin
                    if (key_num) begin
                        op_a_d = W'(key_code);
                        cnt_d  = CW'(1);
                        st_d   = ENTER_A;
                    end else if (key_op || key_eq) begin
                        err_d = 1'b1;
                    end
                end
                ENTER_A: begin
                    if (key_num) begin
                        if (room) begin
                            op_a_d = W'({op_a, key_code});
                            cnt_d  = cnt_q + CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_op) begin
                        op_sub_d = key_code[0];
                        st_d     = OP_WAIT;
                    end
                end
                OP_WAIT: begin
                    if (key_op) begin
                        op_sub_d = key_code[0];
                    end else if (key_num) begin
                        op_b_d = W'(key_code);
                        cnt_d  = CW'(1);
                        st_d   = ENTER_B;
                    end else if (key_eq) begin
                        err_d = 1'b1;
                    end
                end
                ENTER_B: begin
                    if (key_num) begin
                        if (room) begin
                            op_b_d = W'({op_b, key_code});
                            cnt_d  = cnt_q + CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_eq) begin
                        st_d    = CALC;
                        start_d = 1'b1;
                    end else if (key_op) begin
                        err_d = 1'b1;
                    end
                end
                CALC: begin
                    err_d = key_valid;
                    if (alu_done) begin
                        result_d = alu_result;
                        st_d     = SHOW;
                    end
                end
                SHOW: begin
                    if (key_num) begin
                        op_a_d = W'(key_code);
                        op_b_d = '0;
                        cnt_d  = CW'(1);
                        st_d   = ENTER_A;
                    end else if (key_op) begin
                        if (CHAIN) begin
                            op_a_d   = result_q;
                            op_b_d   = '0;
                            op_sub_d = key_code[0];
                            cnt_d    = '0;
                            st_d     = OP_WAIT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: st_d = IDLE;
            endcase
        end

        // Display select follows the state being entered.
        unique case (st_d)
            ENTER_A, OP_WAIT: oe_d = 3'd1;
            ENTER_B, CALC:    oe_d = 3'd2;
            SHOW:             oe_d = 3'd3;
            default:          oe_d = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_calc_key_fsm_multi.sv
// Bench for calc_key_fsm_multi: directed vector table, corner sequences,
// then random keys checked against a key-level reference model (CHAIN=1 and CHAIN=0).
module tb_calc_key_fsm_multi;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         key_valid = 1'b0, key_tipo = 1'b0, alu_done = 1'b0;
    logic [3:0]   key_code = 4'd0;
    logic [W-1:0] alu_result = '0;

    logic [W-1:0] a1, b1, r1, a0, b0, r0;
    logic         sub1, start1, err1, sub0, start0, err0;
    logic [2:0]   oe1, st1, oe0, st0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    calc_key_fsm_multi #(.DIGITS(4), .CHAIN(1'b1)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_tipo(key_tipo),
        .key_code(key_code), .alu_done(alu_done), .alu_result(alu_result),
        .op_a(a1), .op_b(b1), .op_sub(sub1), .calc_start(start1),
        .result_q(r1), .OE(oe1), .err(err1), .state(st1));

    calc_key_fsm_multi #(.DIGITS(4), .CHAIN(1'b0)) dut_nochain (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_tipo(key_tipo),
        .key_code(key_code), .alu_done(alu_done), .alu_result(alu_result),
        .op_a(a0), .op_b(b0), .op_sub(sub0), .calc_start(start0),
        .result_q(r0), .OE(oe0), .err(err0), .state(st0));

    // Reference model: calculator described by key events, not by RTL structure.
    typedef struct {
        int           st;
        int           digits;
        logic [W-1:0] a, b, r;
        bit           sub, start, err;
    } mdl_t;

    mdl_t m1, m0;

    function automatic mdl_t mdl_reset();
        mdl_t z;
        z.st = 0; z.digits = 0; z.a = '0; z.b = '0; z.r = '0;
        z.sub = 0; z.start = 0; z.err = 0;
        return z;
    endfunction

    function automatic int oe_of(int s);
        if (s == 1 || s == 2) return 1;
        if (s == 3 || s == 4) return 2;
        if (s == 5) return 3;
        return 0;
    endfunction

    function automatic mdl_t step(mdl_t m, bit rst_n, bit v, bit t, int c,
                                  bit done, logic [W-1:0] res, bit chain);
        mdl_t n = m;
        bit dig, op, eq, clr;
        n.start = 0;
        n.err   = 0;
        if (!rst_n) return mdl_reset();
        dig = v && !t && c < 10;
        op  = v && t && (c == 10 || c == 11);
        eq  = v && t && c == 12;
        clr = v && t && c == 15;
        if (clr) return mdl_reset();
        if (v && !(dig || op || eq)) n.err = 1;
        case (m.st)
            0: begin
                if (dig) begin n.a = W'(c); n.digits = 1; n.st = 1; end
                if (op || eq) n.err = 1;
            end
            1: begin
                if (dig && m.digits < 4) begin n.a = W'(m.a * 16 + c); n.digits++; end
                else if (dig) n.err = 1;
                if (op) begin n.sub = (c == 11); n.st = 2; end
            end
            2: begin
                if (op) n.sub = (c == 11);
                if (dig) begin n.b = W'(c); n.digits = 1; n.st = 3; end
                if (eq) n.err = 1;
            end
            3: begin
                if (dig && m.digits < 4) begin n.b = W'(m.b * 16 + c); n.digits++; end
                else if (dig) n.err = 1;
                if (eq) begin n.st = 4; n.start = 1; end
                if (op) n.err = 1;
            end
            4: begin
                if (v) n.err = 1;
                if (done) begin n.r = res; n.st = 5; end
            end
            default: begin
                if (dig) begin n.a = W'(c); n.b = '0; n.digits = 1; n.st = 1; end
                if (op && chain) begin n.a = m.r; n.b = '0; n.sub = (c == 11); n.digits = 0; n.st = 2; end
                else if (op) n.err = 1;
            end
        endcase
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, step both models, compare every output of both DUTs.
    task automatic apply(input bit rst_n, input bit v, input bit t, input int c,
                         input bit done, input logic [W-1:0] res);
        @(negedge clk);
        reset = rst_n; key_valid = v; key_tipo = t; key_code = 4'(c);
        alu_done = done; alu_result = res;
        @(posedge clk);
        #1;
        m1 = step(m1, rst_n, v, t, c, done, res, 1'b1);
        m0 = step(m0, rst_n, v, t, c, done, res, 1'b0);
        chk("c1.state", 32'(st1), 32'(m1.st));
        chk("c1.op_a", 32'(a1), 32'(m1.a));
        chk("c1.op_b", 32'(b1), 32'(m1.b));
        chk("c1.result_q", 32'(r1), 32'(m1.r));
        chk("c1.op_sub", 32'(sub1), 32'(m1.sub));
        chk("c1.calc_start", 32'(start1), 32'(m1.start));
        chk("c1.err", 32'(err1), 32'(m1.err));
        chk("c1.OE", 32'(oe1), 32'(oe_of(m1.st)));
        chk("c0.state", 32'(st0), 32'(m0.st));
        chk("c0.op_a", 32'(a0), 32'(m0.a));
        chk("c0.op_b", 32'(b0), 32'(m0.b));
        chk("c0.result_q", 32'(r0), 32'(m0.r));
        chk("c0.op_sub", 32'(sub0), 32'(m0.sub));
        chk("c0.calc_start", 32'(start0), 32'(m0.start));
        chk("c0.err", 32'(err0), 32'(m0.err));
        chk("c0.OE", 32'(oe0), 32'(oe_of(m0.st)));
    endtask

    typedef struct {
        bit           v, t;
        int           c;
        bit           d;
        logic [W-1:0] res;
        int           st;
        logic [W-1:0] a, b, r;
        bit           sub, start;
        int           oe;
        bit           err;
        int           st0;
        bit           err0;
    } vec_t;

    vec_t tbl[28];

    initial begin
        // v t  c  d  res        st a        b        r        sub start oe err st0 err0
        tbl[0]  = '{1,0, 1,0,16'h0000, 1,16'h0001,16'h0000,16'h0000,0,0,1,0, 1,0};
        tbl[1]  = '{1,0, 2,0,16'h0000, 1,16'h0012,16'h0000,16'h0000,0,0,1,0, 1,0};
        tbl[2]  = '{1,0, 3,0,16'h0000, 1,16'h0123,16'h0000,16'h0000,0,0,1,0, 1,0};
        tbl[3]  = '{1,0, 4,0,16'h0000, 1,16'h1234,16'h0000,16'h0000,0,0,1,0, 1,0};
        tbl[4]  = '{1,0, 5,0,16'h0000, 1,16'h1234,16'h0000,16'h0000,0,0,1,1, 1,1};
        tbl[5]  = '{1,1,15,0,16'h0000, 0,16'h0000,16'h0000,16'h0000,0,0,0,0, 0,0};
        tbl[6]  = '{1,0, 7,0,16'h0000, 1,16'h0007,16'h0000,16'h0000,0,0,1,0, 1,0};
        tbl[7]  = '{1,1,10,0,16'h0000, 2,16'h0007,16'h0000,16'h0000,0,0,1,0, 2,0};
        tbl[8]  = '{1,1,11,0,16'h0000, 2,16'h0007,16'h0000,16'h0000,1,0,1,0, 2,0};
        tbl[9]  = '{1,0, 9,0,16'h0000, 3,16'h0007,16'h0009,16'h0000,1,0,2,0, 3,0};
        tbl[10] = '{1,1,12,0,16'h0000, 4,16'h0007,16'h0009,16'h0000,1,1,2,0, 4,0};
        tbl[11] = '{0,0, 0,0,16'h0000, 4,16'h0007,16'h0009,16'h0000,1,0,2,0, 4,0};
        tbl[12] = '{0,0, 0,1,16'h0002, 5,16'h0007,16'h0009,16'h0002,1,0,3,0, 5,0};
        tbl[13] = '{1,0, 1,0,16'h0000, 1,16'h0001,16'h0000,16'h0002,1,0,1,0, 1,0};
        tbl[14] = '{1,1,10,0,16'h0000, 2,16'h0001,16'h0000,16'h0002,0,0,1,0, 2,0};
        tbl[15] = '{1,0, 1,0,16'h0000, 3,16'h0001,16'h0001,16'h0002,0,0,2,0, 3,0};
        tbl[16] = '{1,1,12,0,16'h0000, 4,16'h0001,16'h0001,16'h0002,0,1,2,0, 4,0};
        tbl[17] = '{0,0, 0,1,16'h0012, 5,16'h0001,16'h0001,16'h0012,0,0,3,0, 5,0};
        tbl[18] = '{1,1,10,0,16'h0000, 2,16'h0012,16'h0000,16'h0012,0,0,1,0, 5,1};
        tbl[19] = '{1,0, 3,0,16'h0000, 3,16'h0012,16'h0003,16'h0012,0,0,2,0, 1,0};
        tbl[20] = '{1,1,12,0,16'h0000, 4,16'h0012,16'h0003,16'h0012,0,1,2,0, 1,0};
        tbl[21] = '{1,1,15,1,16'h0099, 0,16'h0000,16'h0000,16'h0000,0,0,0,0, 0,0};
        tbl[22] = '{1,1,12,0,16'h0000, 0,16'h0000,16'h0000,16'h0000,0,0,0,1, 0,1};
        tbl[23] = '{1,0, 4,0,16'h0000, 1,16'h0004,16'h0000,16'h0000,0,0,1,0, 1,0};
        tbl[24] = '{1,0,13,0,16'h0000, 1,16'h0004,16'h0000,16'h0000,0,0,1,1, 1,1};
        tbl[25] = '{0,1,15,0,16'h0000, 1,16'h0004,16'h0000,16'h0000,0,0,1,0, 1,0};
        tbl[26] = '{1,1,14,0,16'h0000, 1,16'h0004,16'h0000,16'h0000,0,0,1,1, 1,1};
        tbl[27] = '{0,0, 0,1,16'h5555, 1,16'h0004,16'h0000,16'h0000,0,0,1,0, 1,0};

        m1 = mdl_reset();
        m0 = mdl_reset();

        // Reset held for two cycles.
        apply(0, 0, 0, 0, 0, '0);
        apply(0, 1, 0, 3, 1, 16'hFFFF);
        apply(1, 0, 0, 0, 0, '0);

        // Directed vectors with hand-computed expectations.
        for (int i = 0; i < 28; i++) begin
            apply(1, tbl[i].v, tbl[i].t, tbl[i].c, tbl[i].d, tbl[i].res);
            chk($sformatf("tbl%0d.state", i), 32'(st1), 32'(tbl[i].st));
            chk($sformatf("tbl%0d.op_a", i), 32'(a1), 32'(tbl[i].a));
            chk($sformatf("tbl%0d.op_b", i), 32'(b1), 32'(tbl[i].b));
            chk($sformatf("tbl%0d.result_q", i), 32'(r1), 32'(tbl[i].r));
            chk($sformatf("tbl%0d.op_sub", i), 32'(sub1), 32'(tbl[i].sub));
            chk($sformatf("tbl%0d.calc_start", i), 32'(start1), 32'(tbl[i].start));
            chk($sformatf("tbl%0d.OE", i), 32'(oe1), 32'(tbl[i].oe));
            chk($sformatf("tbl%0d.err", i), 32'(err1), 32'(tbl[i].err));
            chk($sformatf("tbl%0d.nochain_state", i), 32'(st0), 32'(tbl[i].st0));
            chk($sformatf("tbl%0d.nochain_err", i), 32'(err0), 32'(tbl[i].err0));
        end

        // Keys during CALC are rejected; a long ALU wait keeps state.
        apply(1, 1, 1, 10, 0, '0);
        apply(1, 1, 0, 5, 0, '0);
        apply(1, 1, 1, 12, 0, '0);
        apply(1, 1, 0, 3, 0, '0);
        chk("calc_key.err", 32'(err1), 32'd1);
        chk("calc_key.state", 32'(st1), 32'd4);
        apply(1, 1, 1, 11, 0, '0);
        chk("calc_op.err", 32'(err1), 32'd1);
        apply(1, 0, 0, 0, 0, '0);
        chk("calc_wait.state", 32'(st1), 32'd4);
        chk("calc_wait.start", 32'(start1), 32'd0);

        // Reset mid-CALC aborts; the late alu_done must be ignored.
        apply(0, 0, 0, 0, 0, '0);
        apply(1, 0, 0, 0, 1, 16'h0077);
        chk("abort.state", 32'(st1), 32'd0);
        chk("abort.result_q", 32'(r1), 32'd0);

        // Randomized keys, ALU responses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit rv, v, t, d;
            int c, k;
            rv = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 99) < 70);
            d  = ($urandom_range(0, 5) == 0);
            k  = $urandom_range(0, 19);
            t  = 0;
            c  = $urandom_range(0, 9);
            if (k == 12) begin t = 1; c = 10; end
            else if (k == 13) begin t = 1; c = 11; end
            else if (k == 14) begin t = 1; c = 12; end
            else if (k == 15 && $urandom_range(0, 3) == 0) begin t = 1; c = 15; end
            else if (k == 16) begin t = 0; c = $urandom_range(10, 15); end
            else if (k == 17) begin t = 1; c = $urandom_range(0, 9); end
            else if (k == 18) begin t = 1; c = $urandom_range(13, 14); end
            apply(rv, v, t, c, d, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
